// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, PC step and the loader FSM encoding.
package cpu_pkg;

    localparam int          INSTR_WIDTH = 16;
    localparam logic [15:0] PC_STEP     = 16'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } loader_state_t;

    // Byte address of instruction word idx; wraps at 16 bits.
    function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [15:0] idx);
        return base + idx * PC_STEP;
    endfunction

endpackage

// File: rtl/byte_pair_assembler.sv
// Joins a high and a low byte into one instruction word; word_valid_o pulses
// for one cycle after the low byte is latched.
module byte_pair_assembler
    import cpu_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [7:0]             byte_i,
    input  logic                   hi_en_i,
    input  logic                   lo_en_i,
    output logic [INSTR_WIDTH-1:0] word_o,
    output logic                   word_valid_o
);

    logic [7:0]             hi_q;
    logic [INSTR_WIDTH-1:0] word_q;
    logic                   vld_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hi_q   <= 8'h00;
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            if (hi_en_i) hi_q <= byte_i;
            if (lo_en_i) word_q <= {hi_q, byte_i};
            vld_q <= lo_en_i;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = vld_q;

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: length-prefixed frame -> 16-bit instruction memory writes.
// Optional trailer checksum (XOR of all frame bytes) enabled by LOADER_CHECKSUM_EN.
module program_loader
    import cpu_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        im_we,
    output logic [15:0] im_addr,
    output logic [15:0] im_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_run,
    output logic [15:0] words_loaded
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t ST_END = ST_CHECK;
`else
    localparam loader_state_t ST_END = ST_DONE;
`endif

    loader_state_t state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   idx_q, idx_d;
    logic [15:0]   addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          hi_en, lo_en;
    logic          xfer;
    logic [15:0]   len_full;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    assign byte_ready = (state_q == ST_LEN_HI)  || (state_q == ST_LEN_LO) ||
                        (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                        (state_q == ST_CHECK);
    assign xfer       = byte_valid && byte_ready;
    assign len_full   = {len_q[15:8], byte_in};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        hi_en   = 1'b0;
        lo_en   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    idx_d   = 16'd0;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d   = {byte_in, len_q[7:0]};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full == 16'd0)
                        state_d = ST_END;
                    else if ({16'd0, len_full} > MAX_WORDS)
                        state_d = ST_ERROR;
                    else
                        state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (xfer) begin
                    hi_en   = 1'b1;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (xfer) begin
                    lo_en   = 1'b1;
                    addr_d  = word_addr(BASE_ADDR, idx_q);
                    idx_d   = idx_q + 16'd1;
                    state_d = (idx_q + 16'd1 == len_q) ? ST_END : ST_DATA_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) state_d = (byte_in == csum_q) ? ST_DONE : ST_ERROR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags rise one cycle after the terminal state is entered so the
    // last memory write lands before cpu_run releases the CPU.
    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        if (start && !busy_q &&
            (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR)) begin
            busy_d  = 1'b1;
            done_d  = 1'b0;
            error_d = 1'b0;
        end else if (state_q == ST_DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end else if (state_q == ST_ERROR) begin
            busy_d  = 1'b0;
            error_d = 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_comb begin
        csum_d = csum_q;
        if (start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR))
            csum_d = 8'h00;
        else if (xfer && state_q != ST_CHECK)
            csum_d = csum_q ^ byte_in;
    end
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            len_q   <= 16'd0;
            idx_q   <= 16'd0;
            addr_q  <= BASE_ADDR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    byte_pair_assembler u_asm (
        .CLK          (CLK),
        .RESET        (RESET),
        .byte_i       (byte_in),
        .hi_en_i      (hi_en),
        .lo_en_i      (lo_en),
        .word_o       (im_wdata),
        .word_valid_o (im_we)
    );

    assign im_addr      = addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_run      = done_q;
    assign words_loaded = idx_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes queued at stimulus time,
// popped and compared by an independent monitor on every im_we.
module tb_program_loader;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready, im_we, busy, done, error, cpu_run;
    logic [15:0] im_addr, im_wdata, words_loaded;

    always #5 CLK = ~CLK;

    program_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(256)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .im_we(im_we),
        .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy), .done(done),
        .error(error), .cpu_run(cpu_run), .words_loaded(words_loaded)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_we_cyc = -1;
    wr_t        exp_q[$];
    logic [7:0] tx_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        wr_t e;
        if (im_we) begin
            last_we_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual=%h:%h required=none", im_addr, im_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({im_addr, im_wdata} !== e) begin
                    failures++;
                    $display("FAIL write actual=%h:%h required=%h:%h", im_addr, im_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge CLK);
            #1;
        end
        byte_in = b;
        byte_valid = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!byte_ready && n < 50) begin
            n++;
            @(negedge CLK);
        end
        if (!byte_ready) begin
            checks++;
            failures++;
            $display("FAIL byte_accept actual=stalled required=ready byte=%h", b);
        end
        @(posedge CLK); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_raw(input int maxgap);
        foreach (tx_q[i]) send_byte(tx_q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        tx_q.delete();
    endtask

    task automatic send_frame(input int maxgap);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (tx_q[i]) x ^= tx_q[i];
        tx_q.push_back(x);
`endif
        send_raw(maxgap);
    endtask

    task automatic add_word(input int idx, input logic [15:0] w);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
        exp_q.push_back({16'(idx * 2), w});
    endtask

    task automatic add_frame3();
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h03);
        add_word(0, 16'h1234);
        add_word(1, 16'h5678);
        add_word(2, 16'h9ABC);
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (!(done || error) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!(done || error)) begin
            checks++;
            failures++;
            $display("FAIL wait_end actual=timeout required=done_or_error");
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_flags", {byte_ready, im_we, busy, done, error, cpu_run}, 6'b0);
        chk("rst_addr", im_addr, 16'h0000);
        chk("rst_wdata", im_wdata, 16'h0000);
        chk("rst_words", words_loaded, 16'd0);
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("idle_ready", byte_ready, 1'b0);

        // Three-word frame, back-to-back bytes
        do_start();
        chk("t1_busy", busy, 1'b1);
        chk("t1_ready", byte_ready, 1'b1);
        add_frame3();
        send_frame(0);
        wait_end(n);
        chk("t1_done_run", {done, cpu_run, error, busy}, 4'b1100);
        chk("t1_words", words_loaded, 16'd3);
`ifndef LOADER_CHECKSUM_EN
        chk("t1_run_after_last_we", cyc - last_we_cyc, 1);
`endif

        // Empty program
        do_start();
        chk("t2_cleared", {done, cpu_run, words_loaded}, 18'd0);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        send_frame(0);
        wait_end(n);
        chk("t2_done_run", {done, cpu_run, error}, 3'b110);
        chk("t2_words", words_loaded, 16'd0);
`ifndef LOADER_CHECKSUM_EN
        chk("t2_done_latency", n, 2);
`endif

        // Oversized length is rejected, then a new start recovers
        do_start();
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h01);
        send_raw(0);
        wait_end(n);
        chk("t3_error", {error, done, cpu_run, busy, byte_ready}, 5'b10000);
        chk("t3_words", words_loaded, 16'd0);
        do_start();
        chk("t3_recover", {busy, byte_ready, error}, 3'b110);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        send_frame(0);
        wait_end(n);
        chk("t3_recover_done", done, 1'b1);

        // Same three-word frame with random valid gaps
        do_start();
        add_frame3();
        send_frame(3);
        wait_end(n);
        chk("t4_done", {done, cpu_run}, 2'b11);
        chk("t4_words", words_loaded, 16'd3);

        // Asynchronous reset mid-load
        do_start();
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h03);
        tx_q.push_back(8'h12);
        tx_q.push_back(8'h34);
        exp_q.push_back({16'h0000, 16'h1234});
        send_raw(0);
        @(negedge CLK); #1;
        RESET = 1'b0;
        #1;
        chk("t5_async_flags", {byte_ready, im_we, busy, done, error, cpu_run}, 6'b0);
        chk("t5_async_addr", im_addr, 16'h0000);
        chk("t5_async_data", im_wdata, 16'h0000);
        chk("t5_async_words", words_loaded, 16'd0);
        repeat (5) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("t5_pending", exp_q.size(), 0);
        do_start();
        add_frame3();
        send_frame(0);
        wait_end(n);
        chk("t5_reload", {done, cpu_run, words_loaded}, {2'b11, 16'd3});

`ifdef LOADER_CHECKSUM_EN
        // Trailer 67 = 00^01^AB^CD
        do_start();
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h01);
        add_word(0, 16'hABCD);
        tx_q.push_back(8'h67);
        send_raw(0);
        wait_end(n);
        chk("t6_good_trailer", {done, cpu_run, error}, 3'b110);
        do_start();
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h01);
        add_word(0, 16'hABCD);
        tx_q.push_back(8'h00);
        send_raw(0);
        wait_end(n);
        chk("t6_bad_trailer", {error, done, cpu_run}, 3'b100);
        chk("t6_bad_words", words_loaded, 16'd1);
`endif

        repeat (3) @(posedge CLK);
        #1;
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream stage of the 16-bit single-cycle CPU.
- Receives a byte stream (from a UART receiver or testbench), assembles 16-bit instruction words and writes them into instruction memory at consecutive even addresses.
- Holds the CPU idle through `cpu_run` until loading completes.

Parameters:
- BASE_ADDR, 16'h0000, byte address of the first instruction word written.
- MAX_WORDS, 256, largest accepted program length in words. Must be ≤ 32768.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset. Low clears all state.
- start  input  1  single-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- byte_in  input  8  incoming byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte. A transfer occurs when byte_valid && byte_ready.
- im_we  output  1  instruction memory write strobe, one cycle per word.
- im_addr  output  16  instruction memory byte address.
- im_wdata  output  16  instruction word; first received byte is bits [15:8].
- busy  output  1  a load is in progress.
- done  output  1  the load completed successfully. Level, held until the next start.
- error  output  1  the load was rejected. Level, held until the next start.
- cpu_run  output  1  releases the CPU. High only in DONE.
- words_loaded  output  16  count of words written in the current or last load.

Behaviour:
- Reset (RESET low, asynchronous) forces:
  - state=IDLE
  - byte_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0
  - busy=0, done=0, error=0, cpu_run=0, words_loaded=0
- Reset in the middle of a load abandons it. No further im_we is issued. Memory contents already written are left as they are.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 2N data bytes, high byte first.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK (feature only), DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - go to LEN_HI
  - clear done, error, cpu_run, words_loaded and the word index
  - set busy
- byte_ready=1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK. It does not depend on byte_valid.
- LEN_HI: on a transfer, latch len[15:8] and go to LEN_LO.
- LEN_LO: on a transfer, latch len[7:0]. Next state:
  - N=0 → DONE (or CHECK with the feature)
  - N>MAX_WORDS → ERROR
  - otherwise → DATA_HI
- DATA_HI: on a transfer, latch the high byte and go to DATA_LO.
- DATA_LO: on a transfer, register the write:
  - in the next cycle, im_we=1 for exactly one cycle
  - im_addr=BASE_ADDR+2*idx (16-bit wrap)
  - im_wdata={hi,lo}
  - idx and words_loaded increment in that same cycle
  - if this was the last word, go to DONE (or CHECK); otherwise go to DATA_HI
- Back-to-back bytes are accepted every cycle. A write strobe may overlap acceptance of the next high byte.
- Gaps in byte_valid stall the FSM with no side effects.
- DONE: busy=0, done=1, cpu_run=1.
  - The final im_we is issued one cycle before cpu_run rises, so memory is complete when the CPU starts.
- ERROR: busy=0, error=1, byte_ready=0, cpu_run=0.
- start while busy is ignored.
- Bytes arriving in IDLE/DONE/ERROR are not accepted (byte_ready=0).

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - a running XOR of every accepted byte (length and data) is kept
  - after the last data byte (or LEN_LO when N=0), state CHECK accepts one trailer byte
  - trailer equal to the running XOR → DONE
  - otherwise → ERROR; the words already written remain and cpu_run stays 0
- Disabled: no CHECK state and no trailer byte. The last data byte leads directly to DONE.

Decomposition:
- Shared package `cpu_pkg`:
  - FSM state enum `loader_state_t`
  - INSTR_WIDTH=16, PC_STEP=2 (shared with PC/fetch logic)
- One natural sub-module: `byte_pair_assembler`. It latches the high/low bytes and produces the {hi,lo} word plus a word_valid pulse. The FSM, address counter and checksum stay in the top level.

Test Plan:
- start; stream 00 03 12 34 56 78 9A BC with valid every cycle → three im_we pulses at addresses 0000/0002/0004 with data 1234/5678/9ABC; words_loaded=3; done=1 and cpu_run=1 in the cycle after the last write.
- start; stream 00 00 → no im_we; DONE two transfers after start; cpu_run=1.
- start; stream 01 01 (N=257 > MAX_WORDS) → ERROR; error=1; byte_ready=0; no writes; a later start recovers to LEN_HI.
- Random byte_valid gaps on the 3-word frame → identical writes and order to the gap-free case; im_we never asserted twice for one word.
- Pull RESET low after the second data byte → all outputs at reset values immediately (asynchronously); no further writes; fresh start loads correctly.
- With LOADER_CHECKSUM_EN, frame 00 01 AB CD + trailer 67 → DONE; same frame + trailer 00 → ERROR, with word ABCD written at 0000 and cpu_run=0.
